speaker_serializer: RTL and testbench

- Downstream stage of the tone/buzzer generator.
- Consumes the 16-bit parallel audio_left/audio_right samples and serializes them onto the 4-wire stereo DAC interface (MCLK, LRCK, SCK, SDIN) of the board's audio PMOD.
- Generates all DAC clocks from the single system clock with one free-running frame counter.
- Issues a per-frame sample request so upstream stages can align sample updates.

---
 rtl/speaker_serializer_if.sv | 25 ++
 rtl/speaker_serializer.sv | 88 ++++++++
 tb/tb_speaker_serializer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/speaker_serializer_if.sv
// Sample-side bus between the tone/buzzer generator and the stereo DAC
// serializer: the parallel sample pair, the mute request and the per-frame
// sample request strobe that lets upstream align its sample updates.
interface speaker_serializer_if #(
  parameter int SAMPLE_W = 16
);
  logic signed [SAMPLE_W-1:0] audio_left;
  logic signed [SAMPLE_W-1:0] audio_right;
  logic                       mute;
  logic                       sample_req;

  modport master (
    output audio_left,
    output audio_right,
    output mute,
    input  sample_req
  );

  modport slave (
    input  audio_left,
    input  audio_right,
    input  mute,
    output sample_req
  );
endinterface

// File: rtl/speaker_serializer.sv
// Stereo DAC serializer for the audio PMOD (MCLK/LRCK/SCK/SDIN).
// One free-running 9-bit frame counter (512 clk per frame) produces every DAC
// clock; both channel words are captured together at the frame wrap and
// shifted out MSB first, 16 bits per channel half, one bit per SCK period.
// Optional build macro SPEAKER_SERIALIZER_I2S_DELAY_EN: when defined, sdin is
// delayed by one SCK period (I2S framing); when undefined the output is
// left-justified with the MSB in slot 0 of each half.
module speaker_serializer #(
  parameter int SAMPLE_W = 16,
  parameter int MCLK_BIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  speaker_serializer_if.slave aud,
  output logic                mclk,
  output logic                lrck,
  output logic                sck,
  output logic                sdin
);

  localparam logic [8:0] CNT_LAST  = 9'd511;
  localparam logic [8:0] HALF_LAST = 9'd255;

  logic        [8:0]          cnt;
  logic signed [SAMPLE_W-1:0] shreg;
  logic signed [SAMPLE_W-1:0] right_hold;
  logic                       bit_edge;
  logic                       cap_edge;
  logic                       load_edge;

  // Mute replaces the captured word by silence; samples otherwise pass bit-exact.
  function automatic logic signed [SAMPLE_W-1:0] gate_sample(
    input logic signed [SAMPLE_W-1:0] sample,
    input logic                       muted
  );
    return muted ? '0 : sample;
  endfunction

  // Edge events decoded from the current count: each fires on the clk edge
  // that leaves the decoded value behind.
  always_comb begin
    bit_edge  = (cnt[3:0] == 4'hF);
    cap_edge  = (cnt == CNT_LAST);
    load_edge = (cnt == HALF_LAST);
  end

  // Free-running frame counter, wraps 511 -> 0 with no stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 9'd1;
  end

  // Right word is captured alongside the left one so the pair stays coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           right_hold <= '0;
    else if (cap_edge) right_hold <= gate_sample(aud.audio_right, aud.mute);
  end

  // Shift register: left load at frame wrap, right load at mid frame,
  // otherwise one left shift per SCK falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            shreg <= '0;
    else if (cap_edge)  shreg <= gate_sample(aud.audio_left, aud.mute);
    else if (load_edge) shreg <= right_hold;
    else if (bit_edge)  shreg <= {shreg[SAMPLE_W-2:0], 1'b0};
  end

  assign mclk           = cnt[MCLK_BIT];
  assign sck            = cnt[3];
  assign lrck           = cnt[8];
  assign aud.sample_req = cap_edge;

`ifdef SPEAKER_SERIALIZER_I2S_DELAY_EN
  logic sdin_q;

  // One-SCK delay: takes the MSB as it was before this edge's load/shift, so
  // slot 0 of a half still carries bit 0 of the preceding channel word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sdin_q <= 1'b0;
    else if (bit_edge) sdin_q <= shreg[SAMPLE_W-1];
  end

  assign sdin = sdin_q;
`else
  assign sdin = shreg[SAMPLE_W-1];
`endif

endmodule

// File: tb/tb_speaker_serializer.sv
// Self-checking bench for speaker_serializer. A reference model tracks the
// number of clk edges since reset release and the words captured per frame;
// expected pin values are computed from frame position with plain arithmetic.
module tb_speaker_serializer;

  localparam int MB = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mclk, lrck, sck, sdin;

  int checks = 0;
  int errors = 0;

  speaker_serializer_if #(.SAMPLE_W(16)) aif ();

  speaker_serializer #(.SAMPLE_W(16), .MCLK_BIT(MB)) dut (
    .clk  (clk),
    .rst  (rst),
    .aud  (aif),
    .mclk (mclk),
    .lrck (lrck),
    .sck  (sck),
    .sdin (sdin)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned t = 0;          // clk edges since last reset release
  logic [15:0] wl [0:255];     // left word transmitted in frame f
  logic [15:0] wr [0:255];     // right word transmitted in frame f

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t     <= 0;
      wl[0] <= 16'h0;
      wr[0] <= 16'h0;
    end else begin
      if (t % 512 == 511) begin
        wl[8'((t + 1) / 512)] <= aif.mute ? 16'h0 : aif.audio_left;
        wr[8'((t + 1) / 512)] <= aif.mute ? 16'h0 : aif.audio_right;
      end
      t <= t + 1;
    end
  end

  function automatic logic exp_sdin(input int unsigned tt);
    int unsigned c, slot;
    logic [7:0]  f;
    logic [15:0] w;
    logic        b;
    f    = 8'(tt / 512);
    c    = tt % 512;
    slot = (c % 256) / 16;
    w    = (c >= 256) ? wr[f] : wl[f];
`ifdef SPEAKER_SERIALIZER_I2S_DELAY_EN
    if (slot == 0) begin
      if (c >= 256)     b = wl[f][0];
      else if (f == 0)  b = 1'b0;
      else              b = wr[f - 8'd1][0];
    end else begin
      b = w[16 - slot];
    end
`else
    b = w[15 - slot];
`endif
    return b;
  endfunction

  // {mclk, sck, lrck, sample_req, sdin}
  function automatic logic [4:0] exp_pins(input int unsigned tt);
    int unsigned c;
    c = tt % 512;
    return {1'((c >> MB) % 2), 1'((c / 8) % 2), 1'(c / 256), (c == 511), exp_sdin(tt)};
  endfunction

  // Move forward (no checking) until the model frame position equals pos.
  task automatic advance_to(input int unsigned pos);
    for (int i = 0; i < 600 && (t % 512) != pos; i++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aif.audio_left  = 16'h0;
    aif.audio_right = 16'h0;
    aif.mute        = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mclk, sck, lrck, aif.sample_req, sdin} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b want 00000", {mclk, sck, lrck, aif.sample_req, sdin});
    end
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      checks++;
      if ({mclk, sck, lrck, aif.sample_req, sdin} !== exp_pins(t)) begin
        errors++;
        $display("FAIL reset_release t=%0d: got %b want %b", t,
                 {mclk, sck, lrck, aif.sample_req, sdin}, exp_pins(t));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pattern();
    logic [15:0] lw, rw;
    int unsigned c;
    lw = '0; rw = '0;
    advance_to(300);
    aif.audio_left  = 16'hA5C3;
    aif.audio_right = 16'h3C5A;
    advance_to(0);
    for (int i = 0; i < 512; i++) begin
      c = t % 512;
      checks++;
      if ({mclk, sck, lrck, aif.sample_req, sdin} !== exp_pins(t)) begin
        errors++;
        $display("FAIL pattern t=%0d: got %b want %b", t,
                 {mclk, sck, lrck, aif.sample_req, sdin}, exp_pins(t));
      end
      if (c % 16 == 8) begin
        if (c < 256) lw[15 - (c % 256) / 16] = sdin;
        else         rw[15 - (c % 256) / 16] = sdin;
      end
      @(negedge clk);
    end
`ifndef SPEAKER_SERIALIZER_I2S_DELAY_EN
    checks++;
    if (lw !== 16'hA5C3) begin
      errors++;
      $display("FAIL pattern_left_word: got %h want a5c3", lw);
    end
    checks++;
    if (rw !== 16'h3C5A) begin
      errors++;
      $display("FAIL pattern_right_word: got %h want 3c5a", rw);
    end
`endif
  endtask

  task automatic test_midframe_change();
    logic [15:0] rw [0:1];
    int unsigned c;
    rw[0] = '0; rw[1] = '0;
    advance_to(0);
    for (int i = 0; i < 1024; i++) begin
      c = t % 512;
      if (i == 100) aif.audio_right = 16'hFFFF;
      checks++;
      if ({mclk, sck, lrck, aif.sample_req, sdin} !== exp_pins(t)) begin
        errors++;
        $display("FAIL midframe t=%0d: got %b want %b", t,
                 {mclk, sck, lrck, aif.sample_req, sdin}, exp_pins(t));
      end
      if (c % 16 == 8 && c >= 256) rw[i / 512][15 - (c % 256) / 16] = sdin;
      @(negedge clk);
    end
`ifndef SPEAKER_SERIALIZER_I2S_DELAY_EN
    checks++;
    if (rw[0] !== 16'h3C5A) begin
      errors++;
      $display("FAIL midframe_current_right: got %h want 3c5a", rw[0]);
    end
    checks++;
    if (rw[1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL midframe_next_right: got %h want ffff", rw[1]);
    end
`endif
  endtask

  task automatic test_mute();
    logic [15:0] lw [0:1];
    logic [15:0] rw [0:1];
    int unsigned c;
    lw[0] = '1; lw[1] = '0; rw[0] = '1; rw[1] = '0;
    advance_to(400);
    aif.audio_left  = 16'h7FFF;
    aif.audio_right = 16'h8000;
    aif.mute        = 1'b1;
    advance_to(0);
    for (int i = 0; i < 1024; i++) begin
      c = t % 512;
      if (i == 400) aif.mute = 1'b0;
      checks++;
      if ({mclk, sck, lrck, aif.sample_req, sdin} !== exp_pins(t)) begin
        errors++;
        $display("FAIL mute t=%0d: got %b want %b", t,
                 {mclk, sck, lrck, aif.sample_req, sdin}, exp_pins(t));
      end
      if (c % 16 == 8) begin
        if (c < 256) lw[i / 512][15 - (c % 256) / 16] = sdin;
        else         rw[i / 512][15 - (c % 256) / 16] = sdin;
      end
      @(negedge clk);
    end
`ifndef SPEAKER_SERIALIZER_I2S_DELAY_EN
    checks++;
    if ({lw[0], rw[0]} !== 32'h0) begin
      errors++;
      $display("FAIL mute_on_words: got %h/%h want 0000/0000", lw[0], rw[0]);
    end
    checks++;
    if ({lw[1], rw[1]} !== 32'h7FFF_8000) begin
      errors++;
      $display("FAIL mute_off_words: got %h/%h want 7fff/8000", lw[1], rw[1]);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 512 * 6; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        aif.audio_left  = 16'($urandom);
        aif.audio_right = 16'($urandom);
        aif.mute        = ($urandom_range(0, 3) == 0);
      end
      checks++;
      if ({mclk, sck, lrck, aif.sample_req, sdin} !== exp_pins(t)) begin
        errors++;
        $display("FAIL random t=%0d: got %b want %b", t,
                 {mclk, sck, lrck, aif.sample_req, sdin}, exp_pins(t));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    int ones;
    ones = 0;
    aif.audio_left  = 16'hFFFF;
    aif.audio_right = 16'hFFFF;
    aif.mute        = 1'b0;
    advance_to(0);
    advance_to(300);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({mclk, sck, lrck, aif.sample_req, sdin} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b want 00000",
               {mclk, sck, lrck, aif.sample_req, sdin});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mclk, sck, lrck, aif.sample_req, sdin} !== 5'b0) begin
        errors++;
        $display("FAIL async_reset_hold: got %b want 00000",
                 {mclk, sck, lrck, aif.sample_req, sdin});
      end
    end
    rst = 1'b0;
    aif.audio_left  = 16'($urandom) | 16'h8001;
    aif.audio_right = 16'($urandom) | 16'h8001;
    for (int i = 0; i < 1024; i++) begin
      if (i < 512 && sdin === 1'b1) ones++;
      checks++;
      if ({mclk, sck, lrck, aif.sample_req, sdin} !== exp_pins(t)) begin
        errors++;
        $display("FAIL after_reset t=%0d: got %b want %b", t,
                 {mclk, sck, lrck, aif.sample_req, sdin}, exp_pins(t));
      end
      @(negedge clk);
    end
    checks++;
    if (ones != 0) begin
      errors++;
      $display("FAIL after_reset_zero_frame: got %0d ones want 0", ones);
    end
  endtask

  task automatic test_format();
    logic [3:0] got;
    got = '0;
    advance_to(300);
    aif.audio_left  = 16'h8001;
    aif.audio_right = 16'h0001;
    aif.mute        = 1'b0;
    advance_to(0);
    for (int i = 0; i < 512 + 16; i++) begin
      checks++;
      if ({mclk, sck, lrck, aif.sample_req, sdin} !== exp_pins(t)) begin
        errors++;
        $display("FAIL format t=%0d: got %b want %b", t,
                 {mclk, sck, lrck, aif.sample_req, sdin}, exp_pins(t));
      end
      if (i == 8)   got[3] = sdin;   // left slot 0
      if (i == 24)  got[2] = sdin;   // left slot 1
      if (i == 264) got[1] = sdin;   // right slot 0
      if (i == 520) got[0] = sdin;   // next-frame left slot 0
      @(negedge clk);
    end
    checks++;
`ifdef SPEAKER_SERIALIZER_I2S_DELAY_EN
    // slot0 prev right bit0 (0001 -> 1 from test_random? use model), slot1 left b15=1,
    // right slot0 = left b0 = 1, next left slot0 = right b0 = 1
    if (got[2:0] !== 3'b111) begin
      errors++;
      $display("FAIL i2s_slots: got %b want 111", got[2:0]);
    end
`else
    // left slot0 = b15 = 1, left slot1 = b14 = 0, right slot0 = b15 = 0, next left slot0 = 1
    if (got !== 4'b1001) begin
      errors++;
      $display("FAIL lj_slots: got %b want 1001", got);
    end
`endif
  endtask

  initial begin
    aif.audio_left  = 16'h0;
    aif.audio_right = 16'h0;
    aif.mute        = 1'b0;
    test_reset();
    test_pattern();
    test_midframe_change();
    test_mute();
    test_random();
    test_async_reset();
    test_format();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
